// File: rtl/com_pkg.sv
// Shared types, header constants and segment layout defaults for the com packet RAM
// read path; com_test uses the same layout defaults to fill the RAM.
package com_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int          DEF_INFO_NUM   = 16;
    localparam int          DEF_DATA_NUM   = 100;
    localparam int          DEF_DAT_NUM    = 6;
    localparam logic [14:0] DEF_INFO_BASE  = 15'h0100;
    localparam logic [14:0] DEF_DAT_BASE   = 15'h1000;
    localparam logic [14:0] DEF_DAT_STRIDE = 15'h1200;

    localparam logic [7:0] INFO_HDR0 = 8'h66;
    localparam logic [7:0] INFO_HDR1 = 8'hBB;
    localparam logic [7:0] DAT_HDR0  = 8'h55;
    localparam logic [7:0] DAT_HDR1  = 8'hAA;
    localparam logic [7:0] DAT_HDR2  = 8'hFF;

    typedef struct packed {
        logic       chk;
        logic [7:0] val;
    } hdr_exp_t;

    // Expected header byte for index idx of segment seg; chk=0 for payload bytes.
    // Frame k travels as segment k+1, and its fourth header byte carries k+1.
    function automatic hdr_exp_t hdr_expect(input logic [2:0] seg, input logic [11:0] idx);
        hdr_exp_t e;
        // NOTE: defaults first, so every path assigns every field and combinational use never infers a latch.
        e.chk = 1'b0;
        e.val = 8'h00;
        if (seg == 3'd0) begin
            case (idx)
                12'd0:   begin e.chk = 1'b1; e.val = INFO_HDR0; end
                12'd1:   begin e.chk = 1'b1; e.val = INFO_HDR1; end
                default: ;
            endcase
        end else begin
            case (idx)
                12'd0:   begin e.chk = 1'b1; e.val = DAT_HDR0; end
                12'd1:   begin e.chk = 1'b1; e.val = DAT_HDR1; end
                12'd2:   begin e.chk = 1'b1; e.val = DAT_HDR2; end
                12'd3:   begin e.chk = 1'b1; e.val = {5'd0, seg}; end
                default: ;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/com_skid_fifo.sv
// Two-entry FIFO between the RAM read port and the byte link; the head entry is
// presented directly, and count feeds the read-issue rule upstream.
module com_skid_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;

    // NOTE: the two storage words are reset so the head reads as zero out of reset; deeper memories would not be.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (cnt != 2'd0);
    assign count = cnt;

endmodule

// File: rtl/com_ram_reader.sv
// Read side of the com packet RAM: on fs streams the INFO segment and DAT_NUM data
// frames onto a valid/ready byte link, checks each segment header, and raises fd.
module com_ram_reader
    import com_pkg::*;
#(
    parameter int          INFO_NUM   = DEF_INFO_NUM,
    parameter int          DATA_NUM   = DEF_DATA_NUM,
    parameter int          DAT_NUM    = DEF_DAT_NUM,
    parameter logic [14:0] INFO_BASE  = DEF_INFO_BASE,
    parameter logic [14:0] DAT_BASE   = DEF_DAT_BASE,
    parameter logic [14:0] DAT_STRIDE = DEF_DAT_STRIDE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    output logic [14:0] ram_data_rxa,
    output logic        ram_data_rxen,
    input  logic [7:0]  ram_data_rxd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic [2:0]  tx_seg,
    output logic        hdr_err
);

    localparam logic [11:0] INFO_M1 = 12'(INFO_NUM - 1);
    localparam logic [11:0] DATA_M1 = 12'(DATA_NUM - 1);

    state_t      state;
    logic [2:0]  seg;
    logic [11:0] rd_cnt;
    logic [11:0] byte_idx;
    logic        rv;
    logic        rv_last;
    logic [1:0]  fifo_cnt;
    logic [8:0]  head;
    logic [11:0] len_m1;
    logic        accept;
    logic        issue;
    logic        last_rd;
    logic        drained;
    logic [14:0] next_base;
    hdr_exp_t    hexp;

    assign len_m1    = (seg == 3'd0) ? INFO_M1 : DATA_M1;
    assign accept    = tx_valid & tx_ready;
    assign last_rd   = (rd_cnt == len_m1);
    assign next_base = DAT_BASE + 15'({12'd0, seg} * DAT_STRIDE);
    assign hexp      = hdr_expect(seg, byte_idx);

    // A read may issue only if the FIFO entries plus the byte already returning, less the
    // byte leaving this cycle, leave a free slot; counting the pop keeps one byte per cycle.
    assign issue = (state == S_RD) &&
                   (({1'b0, fifo_cnt} + {2'b00, rv} - {2'b00, accept}) < 3'd2);

    // The FIFO only ever holds bytes of the current segment, so seg doubles as tx_seg.
    assign drained = !rv && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && accept));

    assign ram_data_rxen = issue;
    assign tx_data       = head[8:1];
    assign tx_last       = head[0];
    assign tx_seg        = seg;

    com_skid_fifo #(
        .WIDTH(9)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rv),
        .push_data({ram_data_rxd, rv_last}),
        .pop      (accept),
        .head     (head),
        .valid    (tx_valid),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            seg          <= 3'd0;
            rd_cnt       <= 12'd0;
            byte_idx     <= 12'd0;
            ram_data_rxa <= 15'd0;
            rv           <= 1'b0;
            rv_last      <= 1'b0;
            fd           <= 1'b0;
            hdr_err      <= 1'b0;
        end else begin
            rv <= issue;
            if (issue) begin
                rv_last      <= last_rd;
                ram_data_rxa <= ram_data_rxa + 15'd1;
                rd_cnt       <= rd_cnt + 12'd1;
            end
            if (accept) begin
                byte_idx <= byte_idx + 12'd1;
                if (hexp.chk && (tx_data != hexp.val)) begin
                    hdr_err <= 1'b1;
                end
            end

            case (state)
                S_IDLE: state <= S_WAIT;
                S_WAIT: begin
                    if (fs) begin
                        state        <= S_RD;
                        seg          <= 3'd0;
                        rd_cnt       <= 12'd0;
                        byte_idx     <= 12'd0;
                        ram_data_rxa <= INFO_BASE;
                        hdr_err      <= 1'b0;
                    end
                end
                S_RD: begin
                    if (issue && last_rd) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (seg == 3'(DAT_NUM)) begin
                        state <= S_DONE;
                        fd    <= 1'b1;
                    end else begin
                        state        <= S_RD;
                        seg          <= seg + 3'd1;
                        rd_cnt       <= 12'd0;
                        byte_idx     <= 12'd0;
                        ram_data_rxa <= next_base;
                    end
                end
                S_DONE: begin
                    if (!fs) begin
                        state <= S_WAIT;
                        fd    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_com_ram_reader.sv
// Scoreboard bench for com_ram_reader: a RAM model feeds the reader, expected bytes are
// queued when fs is raised and compared as the link accepts them.
module tb_com_ram_reader;

    localparam int INFO_NUM   = 16;
    localparam int DATA_NUM   = 100;
    localparam int DAT_NUM    = 6;
    localparam int INFO_BASE  = 'h0100;
    localparam int DAT_BASE   = 'h1000;
    localparam int DAT_STRIDE = 'h1200;
    localparam int S_DATA_NUM = 5;
    localparam int S_DAT_BASE = 'h7FFE;

    typedef struct packed {
        logic [2:0] seg;
        logic [7:0] data;
        logic       last;
        logic       bad;
    } item_t;

    logic        clk, rst, fs, fd, rxen, tx_valid, tx_ready, tx_last, hdr_err;
    logic [14:0] rxa;
    logic [7:0]  rxd, tx_data;
    logic [2:0]  tx_seg;
    logic        s_fs, s_fd, s_rxen, s_valid, s_ready, s_last, s_hdr;
    logic [14:0] s_rxa;
    logic [7:0]  s_rxd, s_data;
    logic [2:0]  s_seg;

    logic [7:0]  mem [0:32767];
    item_t       exp_q[$];
    item_t       s_q[$];
    int          checks = 0;
    int          errors = 0;
    int          issued = 0, accepted = 0, max_out = 0, idle_run = 0, max_idle = 0;
    int          ready_mode = 1;
    logic        hdr_model = 1'b0, pend_err = 1'b0, hold_prev = 1'b0;
    logic [12:0] prev_snap = '0;

    com_ram_reader u_dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd),
        .ram_data_rxa(rxa), .ram_data_rxen(rxen), .ram_data_rxd(rxd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .tx_seg(tx_seg), .hdr_err(hdr_err)
    );

    com_ram_reader #(
        .DAT_NUM(1), .DATA_NUM(S_DATA_NUM), .DAT_BASE(15'(S_DAT_BASE))
    ) u_small (
        .clk(clk), .rst(rst), .fs(s_fs), .fd(s_fd),
        .ram_data_rxa(s_rxa), .ram_data_rxen(s_rxen), .ram_data_rxd(s_rxd),
        .tx_data(s_data), .tx_valid(s_valid), .tx_ready(s_ready),
        .tx_last(s_last), .tx_seg(s_seg), .hdr_err(s_hdr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read RAM: data appears the cycle after rxen is sampled.
    always @(posedge clk) begin
        if (rxen)   rxd   <= mem[rxa];
        if (s_rxen) s_rxd <= mem[s_rxa];
    end

    // Backpressure for the main instance: 0 stall, 1 always ready, 2 random.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int seg_base(input int s, input int dbase);
        return (s == 0) ? INFO_BASE : ((dbase + (s - 1) * DAT_STRIDE) & 'h7FFF);
    endfunction

    // {chk, value} of the header byte the reader should see at index i of segment s.
    function automatic logic [8:0] hdr_ref(input int s, input int i);
        if (s == 0) begin
            if (i == 0) return {1'b1, 8'h66};
            if (i == 1) return {1'b1, 8'hBB};
            return 9'h000;
        end
        if (i == 0) return {1'b1, 8'h55};
        if (i == 1) return {1'b1, 8'hAA};
        if (i == 2) return {1'b1, 8'hFF};
        if (i == 3) return {1'b1, 8'(s)};
        return 9'h000;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < INFO_NUM; i++) begin
            mem[15'(INFO_BASE + i)] = (i == 0) ? 8'h66 : (i == 1) ? 8'hBB : 8'(16 + i);
        end
        for (int k = 0; k < DAT_NUM; k++) begin
            for (int i = 0; i < DATA_NUM; i++) begin
                mem[15'(DAT_BASE + k * DAT_STRIDE + i)] =
                    (i == 0) ? 8'h55 : (i == 1) ? 8'hAA : (i == 2) ? 8'hFF :
                    (i == 3) ? 8'(k + 1) : 8'(32 + i + 16 * k);
            end
        end
    endtask

    task automatic push_transfer(input int ndat, input int dlen, input int dbase, input bit to_small);
        for (int s = 0; s <= ndat; s++) begin
            int len;
            len = (s == 0) ? INFO_NUM : dlen;
            for (int i = 0; i < len; i++) begin
                item_t      it;
                logic [8:0] h;
                it.seg  = 3'(s);
                it.data = mem[15'(seg_base(s, dbase) + i)];
                it.last = (i == len - 1);
                h       = hdr_ref(s, i);
                it.bad  = h[8] && (h[7:0] != it.data);
                if (to_small) s_q.push_back(it);
                else          exp_q.push_back(it);
            end
        end
    endtask

    task automatic start_main();
        push_transfer(DAT_NUM, DATA_NUM, DAT_BASE, 1'b0);
        hdr_model = 1'b0;
        max_out   = 0;
        max_idle  = 0;
        idle_run  = 0;
        fs        = 1'b1;
    endtask

    task automatic wait_fd(input string tag, input int budget);
        int n;
        n = 0;
        while (fd !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(fd), 32'd1);
        check({tag, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: scoreboard compare on accept, stability under stall, header-error model.
    always @(negedge clk) begin
        item_t it;
        if (pend_err) begin
            hdr_model = 1'b1;
            pend_err  = 1'b0;
        end
        if (hold_prev && rst) begin
            check("stall_stable", 32'({tx_valid, tx_seg, tx_data, tx_last}), 32'(prev_snap));
        end
        if (rxen) issued++;
        if (tx_valid) idle_run = 0;
        else if (exp_q.size() != 0) begin
            idle_run++;
            if (idle_run > max_idle) max_idle = idle_run;
        end
        if (tx_valid && tx_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'({tx_seg, tx_data, tx_last}), 32'hFFFF_FFFF);
            end else begin
                it = exp_q.pop_front();
                check("byte", 32'({tx_seg, tx_data, tx_last}), 32'({it.seg, it.data, it.last}));
                check("hdr_err_track", 32'(hdr_err), 32'(hdr_model));
                if (it.bad) pend_err = 1'b1;
            end
        end
        if (issued - accepted > max_out) max_out = issued - accepted;
        hold_prev = tx_valid && !tx_ready && rst;
        prev_snap = {tx_valid, tx_seg, tx_data, tx_last};
    end

    initial begin
        int snap;
        int n;
        int idx;
        item_t it;
        fs      = 1'b0;
        s_fs    = 1'b0;
        s_ready = 1'b0;
        rst     = 1'b1;
        fill_mem();
        #3 rst = 1'b0;
        #1;
        check("rst_fd", 32'(fd), 32'd0);
        check("rst_rxen", 32'(rxen), 32'd0);
        check("rst_rxa", 32'(rxa), 32'd0);
        check("rst_tx", 32'({tx_valid, tx_last, tx_data, tx_seg, hdr_err}), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();

        // 1: full-rate transfer
        ready_mode = 1;
        start_main();
        wait_fd("t1_fd", 2000);
        check("t1_hdr_err", 32'(hdr_err), 32'd0);
        check("t1_max_gap_le4", 32'(max_idle <= 4), 32'd1);
        check("t1_outstanding_le2", 32'(max_out <= 2), 32'd1);
        fs = 1'b0;
        repeat (3) tick();

        // 2: random backpressure
        ready_mode = 2;
        start_main();
        wait_fd("t2_fd", 5000);
        check("t2_hdr_err", 32'(hdr_err), 32'd0);
        check("t2_outstanding_le2", 32'(max_out <= 2), 32'd1);
        fs = 1'b0;
        repeat (3) tick();

        // 3: corrupted header byte 3 of frame 2
        ready_mode = 1;
        mem[15'(DAT_BASE + 2 * DAT_STRIDE + 3)] = 8'h07;
        start_main();
        wait_fd("t3_fd", 2000);
        repeat (3) tick();
        check("t3_hdr_err_done", 32'(hdr_err), 32'd1);
        check("t3_fd_held", 32'(fd), 32'd1);
        mem[15'(DAT_BASE + 2 * DAT_STRIDE + 3)] = 8'h03;
        fs = 1'b0;
        repeat (3) tick();

        // 4: fs held after fd, then a second transfer (also proves hdr_err cleared)
        start_main();
        wait_fd("t4_fd", 2000);
        snap = issued;
        repeat (20) tick();
        check("t4_no_reads_in_done", 32'(issued - snap), 32'd0);
        check("t4_fd_held", 32'(fd), 32'd1);
        fs = 1'b0;
        repeat (2) tick();
        check("t4_fd_drop", 32'(fd), 32'd0);
        start_main();
        wait_fd("t4_second_fd", 2000);
        check("t4_second_hdr_err", 32'(hdr_err), 32'd0);
        fs = 1'b0;
        repeat (3) tick();

        // 5: reset mid-frame 2
        start_main();
        n = 0;
        while (!(tx_seg == 3'd3 && tx_valid) && n < 2000) begin
            tick();
            n++;
        end
        check("t5_reach_seg3", 32'(tx_seg), 32'd3);
        repeat (10) tick();
        rst = 1'b0;
        fs  = 1'b0;
        #1;
        check("t5_rst_fd_rxen_rxa", 32'({fd, rxen, rxa}), 32'd0);
        check("t5_rst_tx", 32'({tx_valid, tx_last, tx_data, tx_seg, hdr_err}), 32'd0);
        exp_q.delete();
        issued   = 0;
        accepted = 0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        start_main();
        wait_fd("t5_after_rst_fd", 2000);
        check("t5_hdr_err", 32'(hdr_err), 32'd0);
        fs = 1'b0;
        repeat (3) tick();

        // 6: small instance, frame wrapping 7FFF->0000, 20 cycles of stall
        for (int i = 0; i < S_DATA_NUM; i++) begin
            mem[15'(S_DAT_BASE + i)] = (i == 0) ? 8'h55 : (i == 1) ? 8'hAA :
                                       (i == 2) ? 8'hFF : (i == 3) ? 8'h01 : 8'h24;
        end
        push_transfer(1, S_DATA_NUM, S_DAT_BASE, 1'b1);
        s_ready = 1'b0;
        s_fs    = 1'b1;
        snap    = 0;
        repeat (20) begin
            tick();
            if (s_rxen) snap++;
        end
        check("t6_reads_le2_stalled", 32'(snap <= 2), 32'd1);
        check("t6_rxen_held_low", 32'(s_rxen), 32'd0);
        check("t6_valid_stalled", 32'(s_valid), 32'd1);
        s_ready = 1'b1;
        idx = 0;
        n   = 0;
        while (idx < INFO_NUM + S_DATA_NUM && n < 200) begin
            if (s_valid && s_ready) begin
                it = s_q.pop_front();
                check("t6_byte", 32'({s_seg, s_data, s_last}), 32'({it.seg, it.data, it.last}));
                idx++;
            end
            tick();
            n++;
        end
        check("t6_byte_count", 32'(idx), 32'(INFO_NUM + S_DATA_NUM));
        n = 0;
        while (s_fd !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("t6_fd", 32'(s_fd), 32'd1);
        check("t6_hdr_err", 32'(s_hdr), 32'd0);
        s_fs = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
